// File: rtl/test_sdram_write.sv
// SDRAM frame-store pattern writer: walks frame/y/x in address order and issues Avalon-MM writes.
// Optional TEST_WRITE_CHECKSUM_EN adds oCHECKSUM, the running 16-bit sum of accepted data words.
module test_sdram_write #(
  parameter int NUM_FRAMES     = 64,
  parameter int NUM_LINES      = 1024,
  parameter int WORDS_PER_LINE = 512
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iWAIT_REQUEST,
  output logic        oWR_EN,
  output logic [24:0] oWR_ADDR,
  output logic [15:0] oWR_DATA,
  output logic        oWR_DONE,
  output logic        oBUSY
`ifdef TEST_WRITE_CHECKSUM_EN
  ,
  output logic [15:0] oCHECKSUM
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;

  localparam logic [5:0] FRAME_LAST = 6'(NUM_FRAMES - 1);
  localparam logic [9:0] Y_LAST     = 10'(NUM_LINES - 1);
  localparam logic [8:0] X_LAST     = 9'(WORDS_PER_LINE - 1);

  state_t     state, nxt_state;
  logic [5:0] frame, nxt_frame;
  logic [9:0] y, nxt_y;
  logic [8:0] x, nxt_x;
  logic       accept, restart, last;
  logic [7:0] pat_hi, pat_lo;

  assign last = (frame == FRAME_LAST) && (y == Y_LAST) && (x == X_LAST);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ST_IDLE;
    else      state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    nxt_frame = frame;
    nxt_y     = y;
    nxt_x     = x;
    accept    = 1'b0;
    restart   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (iSTART) begin
          restart   = 1'b1;
          nxt_state = ST_WRITE;
          nxt_frame = '0;
          nxt_y     = '0;
          nxt_x     = '0;
        end
      end
      ST_WRITE: begin
        if (!iWAIT_REQUEST) begin
          accept = 1'b1;
          // Counters stop on the final word so the address holds in ST_DONE.
          if (last) nxt_state = ST_DONE;
          else if (x == X_LAST) begin
            nxt_x = '0;
            if (y == Y_LAST) begin
              nxt_y     = '0;
              nxt_frame = frame + 6'd1;
            end else begin
              nxt_y = y + 10'd1;
            end
          end else begin
            nxt_x = x + 9'd1;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Data is computed from the next coordinates so it lines up with the registered address.
  assign pat_hi = nxt_x[7:0] ^ {2'b00, nxt_frame};
  assign pat_lo = nxt_y[7:0] + {2'b00, nxt_frame};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      frame    <= '0;
      y        <= '0;
      x        <= '0;
      oWR_DATA <= '0;
    end else begin
      frame    <= nxt_frame;
      y        <= nxt_y;
      x        <= nxt_x;
      oWR_DATA <= {pat_hi, pat_lo};
    end
  end

`ifdef TEST_WRITE_CHECKSUM_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)        oCHECKSUM <= '0;
    else if (restart) oCHECKSUM <= '0;
    else if (accept)  oCHECKSUM <= oCHECKSUM + oWR_DATA;
  end
`else
  logic unused_sig;
  assign unused_sig = restart ^ accept;
`endif

  assign oWR_ADDR = {frame, y, x};
  assign oWR_EN   = (state == ST_WRITE);
  assign oBUSY    = (state == ST_WRITE);
  assign oWR_DONE = (state == ST_DONE);

endmodule

// File: tb/tb_test_sdram_write.sv
// Directed/randomized bench for test_sdram_write against an address-order reference word list.
module tb_test_sdram_write;
  localparam int NF = 2, NL = 2, WPL = 4;
  localparam int N  = NF * NL * WPL;

  logic        iCLK = 1'b0, iRST = 1'b1, iSTART = 1'b0, iWAIT_REQUEST = 1'b0;
  logic        oWR_EN, oWR_DONE, oBUSY;
  logic [24:0] oWR_ADDR;
  logic [15:0] oWR_DATA;
`ifdef TEST_WRITE_CHECKSUM_EN
  logic [15:0] oCHECKSUM;
`endif

  int passed = 0, total = 0;
  int exp_addr[N];
  int exp_data[N];

  test_sdram_write #(.NUM_FRAMES(NF), .NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iWAIT_REQUEST(iWAIT_REQUEST),
    .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA),
    .oWR_DONE(oWR_DONE), .oBUSY(oBUSY)
`ifdef TEST_WRITE_CHECKSUM_EN
    , .oCHECKSUM(oCHECKSUM)
`endif
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Runs one fill from a start pulse; abort_at >= 0 asserts reset after that many accepts.
  task automatic fill(input int first_stall, input bit rand_stall, input bit mid_start,
                      input int abort_at);
    int idx = 0, edges = 0, stalls = 0, cs = 0;
    bit w;
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    chk("start_en", oWR_EN, 1);
    chk("start_busy", oBUSY, 1);
    chk("start_done", oWR_DONE, 0);
    chk("start_addr", oWR_ADDR, 0);
    chk("start_data", oWR_DATA, 0);
    while (idx < N && edges < 500) begin
      if (abort_at >= 0 && idx == abort_at) begin
        #2 iRST = 1'b1;
        #1;
        chk("rst_en", oWR_EN, 0);
        chk("rst_busy", oBUSY, 0);
        chk("rst_done", oWR_DONE, 0);
        chk("rst_addr", oWR_ADDR, 0);
        step();
        iRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
          step();
          chk("post_rst_en", oWR_EN, 0);
        end
        return;
      end
      chk("en", oWR_EN, 1);
      chk("addr", oWR_ADDR, exp_addr[idx]);
      chk("data", oWR_DATA, exp_data[idx]);
      w = (edges < first_stall) || (rand_stall && $urandom_range(0, 3) == 0);
      iWAIT_REQUEST = w;
      iSTART = mid_start && (idx == 5);
      step();
      edges++;
      if (!w) begin
        cs += exp_data[idx];
        idx++;
      end else stalls++;
    end
    iWAIT_REQUEST = 1'b0;
    iSTART = 1'b0;
    chk("word_count", idx, N);
    chk("edges_to_done", edges, N + stalls);
    chk("done", oWR_DONE, 1);
    chk("done_en", oWR_EN, 0);
    chk("done_busy", oBUSY, 0);
    chk("done_addr_hold", oWR_ADDR, exp_addr[N-1]);
`ifdef TEST_WRITE_CHECKSUM_EN
    chk("checksum", oCHECKSUM, cs & 16'hFFFF);
`endif
    // Done is sticky and nothing moves while idle in ST_DONE.
    step();
    step();
    chk("done_sticky", oWR_DONE, 1);
    chk("done_idle_en", oWR_EN, 0);
    chk("done_idle_addr", oWR_ADDR, exp_addr[N-1]);
  endtask

  initial begin
    for (int f = 0; f < NF; f++)
      for (int yy = 0; yy < NL; yy++)
        for (int xx = 0; xx < WPL; xx++) begin
          int k;
          k = (f * NL + yy) * WPL + xx;
          exp_addr[k] = (f << 19) | (yy << 9) | xx;
          exp_data[k] = (((xx ^ f) & 255) << 8) | ((yy + f) & 255);
        end

    #12;
    chk("reset_en", oWR_EN, 0);
    chk("reset_done", oWR_DONE, 0);
    chk("reset_busy", oBUSY, 0);
    chk("reset_addr", oWR_ADDR, 0);
    chk("reset_data", oWR_DATA, 0);
    step();
    iRST = 1'b0;
    step();
    chk("idle_en", oWR_EN, 0);

    fill(0, 1'b0, 1'b0, -1);   // no stalls
    fill(0, 1'b0, 1'b0, -1);   // restart from ST_DONE
    fill(3, 1'b0, 1'b0, -1);   // stall first word 3 cycles
    fill(0, 1'b0, 1'b1, -1);   // start re-pulsed mid-fill
    fill(0, 1'b1, 1'b0, -1);   // random stalls
    fill(0, 1'b0, 1'b0, 7);    // reset after 7 accepts
    fill(0, 1'b1, 1'b0, -1);   // restart after reset

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
